// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and pointer helper for the async_fifo stream reader.
package fifo_stream_reader_pkg;

    localparam int DATW_DEF = 32;
    localparam int CNTW_DEF = 32;
    localparam int DEPTH    = 3;

    typedef logic [1:0] ptr_t;
    typedef logic [1:0] occ_t;

    // Circular pointer over DEPTH slots: 0 -> 1 -> 2 -> 0.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? ptr_t'(0) : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read side plus valid/ready output stream of fifo_stream_reader.
interface fifo_stream_reader_if
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATW = DATW_DEF,
    parameter int CNTW = CNTW_DEF
) ();

    logic            fifo_empty;
    logic [DATW-1:0] fifo_dout;
    logic            fifo_read;
    logic [DATW-1:0] dot;
    logic            dot_valid;
    logic            dot_ready;
    logic [CNTW-1:0] dlv_cnt;

    modport master (
        input  fifo_empty, fifo_dout, dot_ready,
        output fifo_read, dot, dot_valid, dlv_cnt
    );

    modport slave (
        output fifo_empty, fifo_dout, dot_ready,
        input  fifo_read, dot, dot_valid, dlv_cnt
    );

endinterface

// File: rtl/fifo_stream_reader_skid_buf3.sv
// Three-entry circular skid buffer; output holds the last popped word when empty.
module skid_buf3
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATW = DATW_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [DATW-1:0] din_i,
    input  logic            pop_i,
    output logic [DATW-1:0] dout_o,
    output occ_t            occ_o
);

    logic [DATW-1:0] mem_q [DEPTH];
    logic [DATW-1:0] last_q, last_d;
    ptr_t            head_q, head_d;
    ptr_t            tail_q, tail_d;
    occ_t            occ_q, occ_d;
    logic            do_pop;

    assign do_pop = pop_i && (occ_q != '0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        last_d = last_q;
        if (push_i) begin
            tail_d = ptr_inc(tail_q);
        end
        if (do_pop) begin
            head_d = ptr_inc(head_q);
            last_d = mem_q[head_q];
        end
        unique case ({push_i, do_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            last_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            last_q <= last_d;
            if (push_i) begin
                assert (occ_q != 2'd3);
            end
        end
    end

    // Storage needs no reset: it is only visible while occupancy is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[tail_q] <= din_i;
        end
    end

    assign dout_o = (occ_q != '0) ? mem_q[head_q] : last_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of async_fifo: issues reads, buffers, streams, counts.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATW = DATW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    fifo_stream_reader_if.master bus
);

    logic            inflt_q, inflt_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    occ_t            occ;
    logic [2:0]      fill;
    logic            rd;
    logic            pop;
    logic            valid;
    logic [DATW-1:0] head_data;

    assign fill  = {1'b0, occ} + {2'b00, inflt_q};
    // Read issue sees only the FIFO flag and local state, never dot_ready.
    assign rd    = !RST && !bus.fifo_empty && (fill < 3'(DEPTH));
    assign valid = (occ != '0);
    assign pop   = valid && bus.dot_ready;

    always_comb begin
        inflt_d = rd;
        cnt_d   = pop ? cnt_q + CNTW'(1) : cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            inflt_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            inflt_q <= inflt_d;
            cnt_q   <= cnt_d;
        end
    end

    skid_buf3 #(
        .DATW (DATW)
    ) u_buf (
        .clk_i  (CLK),
        .rst_i  (RST),
        .push_i (inflt_q),
        .din_i  (bus.fifo_dout),
        .pop_i  (pop),
        .dout_o (head_data),
        .occ_o  (occ)
    );

    assign bus.fifo_read = rd;
    assign bus.dot       = head_data;
    assign bus.dot_valid = valid;
    assign bus.dlv_cnt   = cnt_q;

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for async_fifo, clocked in the FIFO read-clock domain.
- Issues read strobes against empty and captures dout one cycle later (registered read, latency 1).
- Re-presents the data as a valid/ready stream through a 3-entry skid buffer, so a back-pressuring downstream (merge-tree leaf, checker) sustains 1 word/cycle with no combinational path from ready to read.
- Counts delivered words for debug and scoreboarding.

Parameters:
- DATW, 32, data width; must match async_fifo data width.
- CNTW, 32, width of delivered-word counter.

Ports:
- CLK  in  1  read-domain clock (async_fifo RCLK).
- RST  in  1  synchronous, active-high reset.
- fifo_empty  in  1  async_fifo empty flag.
- fifo_dout  in  DATW  async_fifo data_out; valid the cycle after fifo_read was high.
- fifo_read  out  1  read strobe to async_fifo.
- dot  out  DATW  output data, head of skid buffer.
- dot_valid  out  1  dot holds a word.
- dot_ready  in  1  downstream accepts dot this cycle.
- dlv_cnt  out  CNTW  number of words handed off (dot_valid && dot_ready), modulo 2^CNTW.

Behaviour:
- State:
  - occ: buffer occupancy, 0..3.
  - inflt: registered copy of fifo_read, meaning a word arrives this cycle.
  - buffer: 3-entry circular store with 2-bit head/tail pointers, wrapping 2->0.
- fifo_read = !RST && !fifo_empty && (occ + inflt < 3).
  - Combinational from fifo_empty and registered state only; never depends on dot_ready.
- Push: when inflt=1, fifo_dout is written at tail; tail advances.
- Pop: when dot_valid && dot_ready, head advances.
- Same-cycle push and pop: occ unchanged, both pointers advance.
- The occ+inflt<3 rule guarantees a push never finds occ=3. An overflow attempt is a design error; an assertion must flag it.
- dot_valid = (occ != 0); dot = buffer[head].
  - When occ=0, dot holds its last value. There is no bypass: first-word latency is read-strobe edge -> dot_valid after 2 rising edges.
- Steady state with dot_ready=1 and FIFO non-empty: occ=1, inflt=1, 1 word/cycle.
- dot_ready=0: reads continue until occ+inflt=3, then fifo_read stays 0. No word is lost and order is preserved.
- fifo_empty rising while inflt=1: the in-flight word is still captured; no new read is issued.
- dlv_cnt increments by 1 on each pop and wraps at 2^CNTW to 0.
- Reset (synchronous, any cycle including mid-stream):
  - occ=0, inflt=0, head=tail=0, dlv_cnt=0, dot=0, dot_valid=0.
  - fifo_read=0 while RST=1.
  - A word in flight at reset is discarded. The FIFO is reset by the same RST.
- Behaviour is undefined if the FIFO pulses dout without a preceding read.

Decomposition:
- Shared package: DATW default, buffer depth constant (3), pointer-wrap helper function.
- One natural sub-module: skid_buf3 (3-entry circular buffer with push/pop/occ). fifo_stream_reader wraps it with read-issue logic, inflt register and counter.

Test Plan:
- Reset 40 cycles with FIFO pre-loaded and dot_ready=1 -> fifo_read=0, dot_valid=0, dlv_cnt=0 throughout; first read on the first cycle after RST falls; dot_valid 2 edges later with dot=0.
- FIFO holds 0..99, dot_ready=1 constantly -> dot sequence 0,1,...,99 on 100 consecutive cycles after the first word; dlv_cnt=100; no bubbles.
- dot_ready low for 10 cycles mid-stream -> exactly 3 words buffered (occ=3), fifo_read=0 after that; on ready high the stream resumes in order with no loss or duplicate.
- dot_ready pattern high 4 / low 6 cycles (cnt%10 style throttle) with FIFO writer at half rate -> output is the strict increasing sequence; fifo_read never high while fifo_empty=1.
- fifo_empty asserts the cycle after a read -> the in-flight word is delivered; no further read until empty deasserts.
- RST asserted while occ=2 and inflt=1 -> next cycle occ=0, dot_valid=0, dlv_cnt=0; post-reset stream restarts from the FIFO's first word.
- CNTW=4 override, 17 words delivered -> dlv_cnt=1.
